// File: rtl/regfile_sb_pkg.sv
// Shared widths and levels for the register file / scoreboard slice.
// Optional same-cycle write-to-read forwarding is selected with REGFILE_BYPASS_EN.
package regfile_sb_pkg;

  localparam int unsigned REG_BUS      = 32;
  localparam int unsigned REG_NUM      = 32;
  localparam int unsigned REG_ADDR_BUS = 5;
  localparam int unsigned REG_RD_PORTS = 2;
  localparam int unsigned REG_WR_PORTS = 2;

  localparam logic ENABLED  = 1'b1;
  localparam logic DISABLED = 1'b0;

  localparam logic [REG_BUS-1:0]      ZERO_WORD = '0;
  localparam logic [REG_ADDR_BUS-1:0] ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-side bus of the register file: read ports, write ports,
// scoreboard alloc and the scoreboard vector.
interface regfile_sb_if #(
  parameter int unsigned W     = regfile_sb_pkg::REG_BUS,
  parameter int unsigned DEPTH = regfile_sb_pkg::REG_NUM,
  parameter int unsigned AW    = regfile_sb_pkg::REG_ADDR_BUS,
  parameter int unsigned NR    = regfile_sb_pkg::REG_RD_PORTS,
  parameter int unsigned NW    = regfile_sb_pkg::REG_WR_PORTS
) ();

  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*W-1:0]  wdata;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] raddr;
  logic [NR*W-1:0]  rdata;
  logic [NR-1:0]    rbusy;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic [DEPTH-1:0] busy_vec;

  modport master (
    output we, waddr, wdata, re, raddr, alloc_en, alloc_addr,
    input  rdata, rbusy, busy_vec
  );

  modport slave (
    input  we, waddr, wdata, re, raddr, alloc_en, alloc_addr,
    output rdata, rbusy, busy_vec
  );

endinterface

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: address mux, optional write forwarding, busy lookup.
// Forwarding from same-cycle writes is compiled in with REGFILE_BYPASS_EN.
module regfile_sb_rdport
  import regfile_sb_pkg::*;
#(
  parameter int unsigned W     = REG_BUS,
  parameter int unsigned DEPTH = REG_NUM,
  parameter int unsigned AW    = REG_ADDR_BUS,
  parameter int unsigned NW    = REG_WR_PORTS
) (
  input  logic                    rst,
  input  logic                    re,
  input  logic [AW-1:0]           raddr,
  input  logic [DEPTH-1:0][W-1:0] regs,
  input  logic [DEPTH-1:0]        busy,
  input  logic [NW-1:0]           we,
  input  logic [NW*AW-1:0]        waddr,
  input  logic [NW*W-1:0]         wdata,
  output logic [W-1:0]            rdata_c,
  output logic                    rbusy_c
);

  logic         byp_hit_c;
  logic [W-1:0] byp_data_c;

`ifdef REGFILE_BYPASS_EN
  // Ascending scan so the highest matching write port wins.
  always_comb begin
    byp_hit_c  = 1'b0;
    byp_data_c = '0;
    for (int k = 0; k < int'(NW); k++) begin
      if (we[k] && (waddr[k*AW +: AW] == raddr)) begin
        byp_hit_c  = 1'b1;
        byp_data_c = wdata[k*W +: W];
      end
    end
  end
`else
  logic unused_wr_c;

  assign byp_hit_c   = 1'b0;
  assign byp_data_c  = '0;
  assign unused_wr_c = ^{we, waddr, wdata};
`endif

  // x0 and disabled ports read as zero; reset forces quiet outputs.
  always_comb begin
    rdata_c = '0;
    rbusy_c = 1'b0;
    if (!rst && re && (raddr != '0)) begin
      if (byp_hit_c) begin
        rdata_c = byp_data_c;
      end else begin
        rdata_c = regs[raddr];
        rbusy_c = busy[raddr];
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy scoreboard, x0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned W     = REG_BUS,
  parameter int unsigned DEPTH = REG_NUM,
  parameter int unsigned AW    = REG_ADDR_BUS,
  parameter int unsigned NR    = REG_RD_PORTS,
  parameter int unsigned NW    = REG_WR_PORTS
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  logic [DEPTH-1:0][W-1:0] regs;
  logic [DEPTH-1:0]        busy_q;
  logic [DEPTH-1:0]        busy_d_c;
  logic [NR-1:0][W-1:0]    rd_data_c;
  logic [NR-1:0]           rd_busy_c;

  // Later iterations overwrite earlier ones: highest write port wins a conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int k = 0; k < int'(NW); k++) begin
        if (bus.we[k] && (bus.waddr[k*AW +: AW] != '0)) begin
          regs[bus.waddr[k*AW +: AW]] <= bus.wdata[k*W +: W];
        end
      end
    end
  end

  // Writeback clears, issue sets; set is applied last so it beats a same-cycle clear.
  always_comb begin
    busy_d_c = busy_q;
    for (int k = 0; k < int'(NW); k++) begin
      if (bus.we[k] && (bus.waddr[k*AW +: AW] != '0)) begin
        busy_d_c[bus.waddr[k*AW +: AW]] = 1'b0;
      end
    end
    if (bus.alloc_en && (bus.alloc_addr != '0)) begin
      busy_d_c[bus.alloc_addr] = 1'b1;
    end
    busy_d_c[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d_c;
    end
  end

  assign bus.busy_vec = busy_q;

  for (genvar j = 0; j < int'(NR); j++) begin : g_rd
    regfile_sb_rdport #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW),
      .NW    (NW)
    ) u_rdport (
      .rst     (rst),
      .re      (bus.re[j]),
      .raddr   (bus.raddr[j*AW +: AW]),
      .regs    (regs),
      .busy    (busy_q),
      .we      (bus.we),
      .waddr   (bus.waddr),
      .wdata   (bus.wdata),
      .rdata_c (rd_data_c[j]),
      .rbusy_c (rd_busy_c[j])
    );
  end

  assign bus.rdata = rd_data_c;
  assign bus.rbusy = rd_busy_c;

endmodule
